regfile_write_decoder32: RTL and testbench

//  Write side of the MIPS 32x32 register file: decodes a 5-bit write address into
//  32 one-hot enables and holds the 32 architectural registers.

---
 rtl/regfile_write_decoder32_pkg.sv | 25 ++
 rtl/regfile_write_decoder32_dec.sv | 19 +
 rtl/regfile_write_decoder32.sv | 125 ++++++++++++
 tb/tb_regfile_write_decoder32.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/regfile_write_decoder32_pkg.sv
// Shared register-file constants, MIPS register names and the one-hot decode helper.
// Pure declarations: no latency, no flow control.
// Imported by the write decoder and the register-file top.
package regfile_write_decoder32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_AT   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_V0   = 5'd2;
    localparam logic [REG_ADDR_W-1:0] REG_A0   = 5'd4;
    localparam logic [REG_ADDR_W-1:0] REG_T0   = 5'd8;
    localparam logic [REG_ADDR_W-1:0] REG_S0   = 5'd16;
    localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd28;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_FP   = 5'd30;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    function automatic logic [NUM_REGS-1:0] onehot_addr(input logic [REG_ADDR_W-1:0] a);
        onehot_addr = {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/regfile_write_decoder32_dec.sv
// 5-to-32 one-hot write-enable decoder; dual of the 32-to-1 read mux.
// Combinational, zero latency.
// No flow control: output is all-zero whenever en is low.
module decoder5to32
    import regfile_write_decoder32_pkg::*;
(
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] a,
    output logic [NUM_REGS-1:0]   y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = onehot_addr(a);
        end
    end

endmodule

// File: rtl/regfile_write_decoder32.sv
// Write side of the MIPS 32x32 register file with commit strobe and commit counter.
// Latency 1: a committed write is visible on q[wa] after the clock edge.
// No backpressure: one write accepted per cycle; reset discards a concurrent write.
module regfile_write_decoder32
    import regfile_write_decoder32_pkg::*;
#(
    parameter int WIDTH     = REG_W,
    parameter bit ZERO_HARD = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]      wd,
    output logic                  wr_done,
    output logic [15:0]           wr_count,
    output logic [WIDTH-1:0]      q0,
    output logic [WIDTH-1:0]      q1,
    output logic [WIDTH-1:0]      q2,
    output logic [WIDTH-1:0]      q3,
    output logic [WIDTH-1:0]      q4,
    output logic [WIDTH-1:0]      q5,
    output logic [WIDTH-1:0]      q6,
    output logic [WIDTH-1:0]      q7,
    output logic [WIDTH-1:0]      q8,
    output logic [WIDTH-1:0]      q9,
    output logic [WIDTH-1:0]      q10,
    output logic [WIDTH-1:0]      q11,
    output logic [WIDTH-1:0]      q12,
    output logic [WIDTH-1:0]      q13,
    output logic [WIDTH-1:0]      q14,
    output logic [WIDTH-1:0]      q15,
    output logic [WIDTH-1:0]      q16,
    output logic [WIDTH-1:0]      q17,
    output logic [WIDTH-1:0]      q18,
    output logic [WIDTH-1:0]      q19,
    output logic [WIDTH-1:0]      q20,
    output logic [WIDTH-1:0]      q21,
    output logic [WIDTH-1:0]      q22,
    output logic [WIDTH-1:0]      q23,
    output logic [WIDTH-1:0]      q24,
    output logic [WIDTH-1:0]      q25,
    output logic [WIDTH-1:0]      q26,
    output logic [WIDTH-1:0]      q27,
    output logic [WIDTH-1:0]      q28,
    output logic [WIDTH-1:0]      q29,
    output logic [WIDTH-1:0]      q30,
    output logic [WIDTH-1:0]      q31
);

    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_en;
    logic                w_commit;
    logic [WIDTH-1:0]    r_q [NUM_REGS];
    logic                r_done;
    logic [15:0]         r_count;

    decoder5to32 u_dec (
        .en (we),
        .a  (wa),
        .y  (w_dec)
    );

    // A write to $zero is masked here so it never counts as a commit.
    assign w_en[0]            = w_dec[0] & ~ZERO_HARD;
    assign w_en[NUM_REGS-1:1] = w_dec[NUM_REGS-1:1];
    assign w_commit           = |w_en;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                r_q[i] <= '0;
            end else if (w_en[i]) begin
                r_q[i] <= wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done  <= w_commit;
            r_count <= r_count + {15'd0, w_commit};
        end
    end

    assign wr_done  = r_done;
    assign wr_count = r_count;

    assign q0  = r_q[0];
    assign q1  = r_q[1];
    assign q2  = r_q[2];
    assign q3  = r_q[3];
    assign q4  = r_q[4];
    assign q5  = r_q[5];
    assign q6  = r_q[6];
    assign q7  = r_q[7];
    assign q8  = r_q[8];
    assign q9  = r_q[9];
    assign q10 = r_q[10];
    assign q11 = r_q[11];
    assign q12 = r_q[12];
    assign q13 = r_q[13];
    assign q14 = r_q[14];
    assign q15 = r_q[15];
    assign q16 = r_q[16];
    assign q17 = r_q[17];
    assign q18 = r_q[18];
    assign q19 = r_q[19];
    assign q20 = r_q[20];
    assign q21 = r_q[21];
    assign q22 = r_q[22];
    assign q23 = r_q[23];
    assign q24 = r_q[24];
    assign q25 = r_q[25];
    assign q26 = r_q[26];
    assign q27 = r_q[27];
    assign q28 = r_q[28];
    assign q29 = r_q[29];
    assign q30 = r_q[30];
    assign q31 = r_q[31];

endmodule

// File: tb/tb_regfile_write_decoder32.sv
// Directed bench for regfile_write_decoder32 with a scoreboard of expected register-file state.
module tb_regfile_write_decoder32;

    typedef struct packed {
        logic [1023:0] q;
        logic [15:0]   cnt;
        logic          done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wr_done;
    logic [15:0] wr_count;
    logic [31:0] dq [32];
    logic [1023:0] obs_flat;

    logic [1023:0] m_flat;
    logic [15:0]   m_cnt;
    logic          m_done;
    exp_t          sb [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        obs_flat = '0;
        for (int i = 0; i < 32; i++) obs_flat[i*32 +: 32] = dq[i];
    end

    regfile_write_decoder32 #(.WIDTH(32), .ZERO_HARD(1'b1)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .wr_done(wr_done), .wr_count(wr_count),
        .q0(dq[0]),   .q1(dq[1]),   .q2(dq[2]),   .q3(dq[3]),
        .q4(dq[4]),   .q5(dq[5]),   .q6(dq[6]),   .q7(dq[7]),
        .q8(dq[8]),   .q9(dq[9]),   .q10(dq[10]), .q11(dq[11]),
        .q12(dq[12]), .q13(dq[13]), .q14(dq[14]), .q15(dq[15]),
        .q16(dq[16]), .q17(dq[17]), .q18(dq[18]), .q19(dq[19]),
        .q20(dq[20]), .q21(dq[21]), .q22(dq[22]), .q23(dq[23]),
        .q24(dq[24]), .q25(dq[25]), .q26(dq[26]), .q27(dq[27]),
        .q28(dq[28]), .q29(dq[29]), .q30(dq[30]), .q31(dq[31])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_file(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int bad;
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            bad = 0;
            for (int i = 31; i >= 0; i--) if (obs[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
            $error("FAIL %s: q%0d got 0x%08h expected 0x%08h", tag, bad,
                   obs[bad*32 +: 32], exp[bad*32 +: 32]);
        end
    endtask

    // One clock cycle: drive, predict, push; after the edge pop and compare.
    task automatic cycle(input string tag, input logic rst, input logic w,
                         input logic [4:0] a, input logic [31:0] d, input bit chk_rdw);
        exp_t e;
        logic [31:0] old_val;
        logic        commit;
        @(negedge clk);
        reset = rst; we = w; wa = a; wd = d;
        if (w) begin
            n_checks++;
            assert (!$isunknown({a, d})) n_pass++;
            else $error("FAIL %s_xin: write with unknown wa/wd 0x%02h/0x%08h", tag, a, d);
        end
        old_val = m_flat[a*32 +: 32];
        if (rst) begin
            m_flat = '0; m_cnt = '0; m_done = 1'b0;
        end else begin
            commit = w && (a != 5'd0);
            if (commit) m_flat[a*32 +: 32] = d;
            m_done = commit;
            m_cnt  = m_cnt + {15'd0, commit};
        end
        e.q = m_flat; e.cnt = m_cnt; e.done = m_done;
        sb.push_back(e);
        if (chk_rdw) begin
            #1;
            check({tag, "_rdw_old"}, dq[a], old_val);
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_file({tag, "_q"}, obs_flat, e.q);
            check({tag, "_cnt"}, {16'd0, wr_count}, {16'd0, e.cnt});
            check({tag, "_done"}, {31'd0, wr_done}, {31'd0, e.done});
        end
    endtask

    initial begin
        logic [4:0] sa;
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0;
        m_flat = '0; m_cnt = '0; m_done = 1'b0;

        // 1: reset for two cycles
        cycle("rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle("rst", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        check("rst_q31", dq[31], 32'd0);
        check("rst_cnt", {16'd0, wr_count}, 32'd0);

        // 2: four scattered writes
        cycle("w31", 1'b0, 1'b1, 5'd31, 32'd5,   1'b0);
        check("w31_val", dq[31], 32'd5);
        cycle("w25", 1'b0, 1'b1, 5'd25, 32'd345, 1'b0);
        check("w25_val", dq[25], 32'd345);
        cycle("w6",  1'b0, 1'b1, 5'd6,  32'd35,  1'b0);
        check("w6_val", dq[6], 32'd35);
        cycle("w16", 1'b0, 1'b1, 5'd16, 32'd276, 1'b0);
        check("w16_val", dq[16], 32'd276);
        check("w4_cnt", {16'd0, wr_count}, 32'd4);

        // 3: write to $zero is discarded
        cycle("zero", 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
        check("zero_q0", dq[0], 32'd0);
        check("zero_done", {31'd0, wr_done}, 32'd0);
        check("zero_cnt", {16'd0, wr_count}, 32'd4);

        // 4: idle cycles with we=0, then back-to-back writes to q7
        for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 1'b0, 5'd7, 32'd99, 1'b0);
        check("idle_q7", dq[7], 32'd0);
        cycle("b2b1", 1'b0, 1'b1, 5'd7, 32'd1, 1'b1);
        check("b2b1_q7", dq[7], 32'd1);
        cycle("b2b2", 1'b0, 1'b1, 5'd7, 32'd2, 1'b1);
        check("b2b2_q7", dq[7], 32'd2);
        check("b2b2_done", {31'd0, wr_done}, 32'd1);

        // 5: reset wins over a concurrent write; next write lands normally
        cycle("pre3", 1'b0, 1'b1, 5'd3, 32'd11, 1'b0);
        cycle("rstw", 1'b1, 1'b1, 5'd3, 32'd77, 1'b0);
        check("rstw_q3", dq[3], 32'd0);
        check("rstw_cnt", {16'd0, wr_count}, 32'd0);
        cycle("postrst", 1'b0, 1'b1, 5'd3, 32'd77, 1'b0);
        check("postrst_q3", dq[3], 32'd77);

        // 6: address sweep up to wr_count = 0xFFFF, then wrap
        cycle("rst2", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int k = 0; k < 65535; k++) begin
            sa = 5'((k % 31) + 1);
            cycle("sweep", 1'b0, 1'b1, sa, $urandom, 1'b0);
        end
        check("pre_wrap_cnt", {16'd0, wr_count}, 32'h0000FFFF);
        cycle("wrap", 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0);
        check("wrap_cnt", {16'd0, wr_count}, 32'd0);
        check("wrap_done", {31'd0, wr_done}, 32'd1);

        @(negedge clk);
        we = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
